// File: rtl/sw_debouncer_pkg.sv
// Shared constants and FSM encoding for the slide-switch debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sw_debouncer_pkg;

  // Board default: 10 slide switches, 5 ms settle time at 50 MHz.
  localparam int SW_WIDTH        = 10;
  localparam int DEBOUNCE_CYCLES = 250000;

  // Per-bit filter state: output agrees with input, or a mismatch is being timed.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, clean level and rise/fall pulses.
// Latency: level and pulse update STABLE_CYCLES+2 edges after a raw change that holds.
// Backpressure: none; the input is sampled every cycle and pulses are never held.
module sw_debounce_bit
  import sw_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  // Next-state logic. The counter holds the number of consecutive mismatching
  // samples seen so far, so entering COUNT already counts the first sample and
  // the update fires on the STABLE_CYCLES-th mismatching sample.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync2_q != level_q) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (sync2_q == level_q) begin
          // Input fell back before the window elapsed: treat as bounce.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          level_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, synchroniser and registered outputs; reset discards any count in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sw_debouncer.sv
// Debounces WIDTH slide switches into clean levels plus per-bit rise/fall and a change pulse.
// Latency: STABLE_CYCLES+2 edges from a held raw change to sw_o and its pulse.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_rise_o,
  output logic [WIDTH-1:0] sw_fall_o,
  output logic             sw_changed_o
);

  // Each bit is filtered independently; several may update on the same edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (sw_raw_i[i]),
      .level_o(sw_o[i]),
      .rise_o (sw_rise_o[i]),
      .fall_o (sw_fall_o[i])
    );
  end

  // OR of registered pulses: one pulse however many bits moved, no input-to-output path.
  assign sw_changed_o = |(sw_rise_o | sw_fall_o);

endmodule

// File: tb/tb_sw_debouncer.sv
module tb_sw_debouncer;

  localparam int W   = 10;
  localparam int LAT = 6;  // 2 synchroniser edges + STABLE_CYCLES (4)

  logic         clk = 1'b0;
  logic         rst_i;
  logic [W-1:0] sw_raw_i;
  logic [W-1:0] sw_o;
  logic [W-1:0] sw_rise_o;
  logic [W-1:0] sw_fall_o;
  logic         sw_changed_o;

  sw_debouncer #(
    .WIDTH        (W),
    .STABLE_CYCLES(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .sw_raw_i    (sw_raw_i),
    .sw_o        (sw_o),
    .sw_rise_o   (sw_rise_o),
    .sw_fall_o   (sw_fall_o),
    .sw_changed_o(sw_changed_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } ev_t;

  ev_t          sb[$];
  int           cyc = 0;
  logic         rst_at_edge = 1'b0;
  logic [W-1:0] exp_lvl = '0;
  int           n_vec = 0;
  int           n_miss = 0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_i;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input logic [W-1:0] lvl,
                      input logic [W-1:0] rise, input logic [W-1:0] fall);
    ev_t e;
    e.cyc  = at;
    e.lvl  = lvl;
    e.rise = rise;
    e.fall = fall;
    sb.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, decoupled from stimulus via sb.
  always @(negedge clk) begin
    ev_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_event_cycle", cyc, e.cyc);
    end
    if (rst_at_edge) begin
      exp_lvl = '0;
      chk("reset_sw_o",      int'(sw_o),         0);
      chk("reset_rise",      int'(sw_rise_o),    0);
      chk("reset_fall",      int'(sw_fall_o),    0);
      chk("reset_changed",   int'(sw_changed_o), 0);
    end else if (sw_changed_o || (sb.size() > 0 && sb[0].cyc == cyc)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse_rise", int'(sw_rise_o), 0);
        chk("unexpected_pulse_fall", int'(sw_fall_o), 0);
      end else begin
        e = sb.pop_front();
        chk("event_cycle",   cyc,                e.cyc);
        chk("event_sw_o",    int'(sw_o),         int'(e.lvl));
        chk("event_rise",    int'(sw_rise_o),    int'(e.rise));
        chk("event_fall",    int'(sw_fall_o),    int'(e.fall));
        chk("event_changed", int'(sw_changed_o), 1);
        exp_lvl = e.lvl;
      end
    end else begin
      chk("idle_sw_o", int'(sw_o),      int'(exp_lvl));
      chk("idle_rise", int'(sw_rise_o), 0);
      chk("idle_fall", int'(sw_fall_o), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, sb size %0d", sb.size());
    $fatal(1);
  end

  initial begin
    // Reset with all switches already high: afresh debounce gives one rise on all bits.
    rst_i    = 1'b1;
    sw_raw_i = 10'h3FF;
    tick(3);
    rst_i = 1'b0;
    push(cyc + LAT, 10'h3FF, 10'h3FF, 10'h000);
    tick(10);

    // Simultaneous release of every bit.
    sw_raw_i = 10'h000;
    push(cyc + LAT, 10'h000, 10'h000, 10'h3FF);
    tick(10);

    // Clean press on bit 0.
    sw_raw_i = 10'h001;
    push(cyc + LAT, 10'h001, 10'h001, 10'h000);
    tick(10);

    // Bounce on bit 3: 1,0,1,0 then hold 1.
    sw_raw_i = 10'h009; tick(1);
    sw_raw_i = 10'h001; tick(1);
    sw_raw_i = 10'h009; tick(1);
    sw_raw_i = 10'h001; tick(1);
    sw_raw_i = 10'h009;
    push(cyc + LAT, 10'h009, 10'h008, 10'h000);
    tick(10);

    // Short glitch on bit 5: three cycles high, no output activity.
    sw_raw_i = 10'h029; tick(3);
    sw_raw_i = 10'h009;
    tick(10);

    // Reset mid-count on bit 2; bits 0 and 3 are also re-debounced after release.
    sw_raw_i = 10'h00D;
    tick(3);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    push(cyc + LAT, 10'h00D, 10'h00D, 10'h000);
    tick(10);

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
